// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: gated-counter state encoding, default widths and
// the gate-length clamp used when a counting window is (re)started.
package adpll_pkg;

   localparam int DEFAULT_WIDTH      = 20;
   localparam int DEFAULT_GATE_WIDTH = 20;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_COUNT = 1'b1;

   // A zero-length window has no terminal cycle, so it runs as a one-cycle window.
   // Callers wider than 32 bits are not supported.
   function automatic logic [31:0] clamp_gate_len(input logic [31:0] len);
      return (len == 32'd0) ? 32'd1 : len;
   endfunction

endpackage

// File: rtl/edge_window_counter_if.sv
// Counter-value / trigger bundle between the gated edge counter (master)
// and the ADPLL save/capture stage (slave).
interface edge_window_counter_if #(
   parameter int WIDTH      = adpll_pkg::DEFAULT_WIDTH,
   parameter int GATE_WIDTH = adpll_pkg::DEFAULT_GATE_WIDTH
);

   logic                  enable;
   logic [GATE_WIDTH-1:0] gate_len;
   logic                  sig;
   logic [WIDTH-1:0]      counter_val;
   logic [WIDTH-1:0]      count;
   logic                  count_valid;
   logic                  trigger;
   logic                  overflow;
   logic                  counter_cleared;

   // Handshake: count_valid (and its twin trigger) is a one-cycle strobe with
   // no ready; count/overflow are valid with it and hold until the next
   // strobe, so the slave must capture on the strobe or wait for the next one.
   modport master (
      input  enable, gate_len, sig,
      output counter_val, count, count_valid, trigger, overflow, counter_cleared
   );

   modport slave (
      output enable, gate_len, sig,
      input  counter_val, count, count_valid, trigger, overflow, counter_cleared
   );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous input plus a one-cycle pulse on
// each synchronised rising edge.
module sync_edge_detect (
   input  logic clk_i,
   input  logic reset_i,
   input  logic sig_i,
   output logic edge_o
);

   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= sig_i;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign edge_o = sync2 & ~prev;

endmodule

// File: rtl/edge_window_counter.sv
// Gated edge counter: counts synchronised rising edges of sig_i over windows of
// gate_len_i clock cycles and publishes each final count with a one-cycle strobe.
module edge_window_counter
   import adpll_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int GATE_WIDTH = DEFAULT_GATE_WIDTH
) (
   input  logic                  fpga_clk_i,
   input  logic                  reset_i,
   input  logic                  enable_i,
   input  logic [GATE_WIDTH-1:0] gate_len_i,
   input  logic                  sig_i,
   output logic [WIDTH-1:0]      counter_val_o,
   output logic [WIDTH-1:0]      count_o,
   output logic                  count_valid_o,
   output logic                  trigger_o,
   output logic                  overflow_o,
   output logic                  counter_cleared_o
);

   localparam logic [GATE_WIDTH-1:0] GATE_ONE = GATE_WIDTH'(1);
   localparam logic [WIDTH-1:0]      EDGE_ONE = WIDTH'(1);

   state_t                state;
   logic [GATE_WIDTH-1:0] gate_len_q;
   logic [GATE_WIDTH-1:0] gate_cnt;
   logic [WIDTH-1:0]      edge_cnt;
   logic                  sticky_ovf;
   logic [WIDTH-1:0]      count_q;
   logic                  ovf_q;
   logic                  valid_q;

   logic                  detect;
   logic [GATE_WIDTH-1:0] start_len;
   logic                  terminal;
   logic                  edge_at_max;
   logic [WIDTH-1:0]      edge_cnt_nxt;
   logic                  sticky_nxt;

   sync_edge_detect u_sync (
      .clk_i   (fpga_clk_i),
      .reset_i (reset_i),
      .sig_i   (sig_i),
      .edge_o  (detect)
   );

   assign start_len = GATE_WIDTH'(clamp_gate_len(32'(gate_len_i)));
   assign terminal  = (state == ST_COUNT) && (gate_cnt == gate_len_q - GATE_ONE);

   // The edge counter holds at all-ones; any further edge marks the window overflowed.
   assign edge_at_max  = &edge_cnt;
   assign edge_cnt_nxt = (detect && !edge_at_max) ? edge_cnt + EDGE_ONE : edge_cnt;
   assign sticky_nxt   = sticky_ovf | (detect & edge_at_max);

   always_ff @(posedge fpga_clk_i) begin
      if (reset_i) begin
         state      <= ST_IDLE;
         gate_len_q <= GATE_ONE;
         gate_cnt   <= '0;
         edge_cnt   <= '0;
         sticky_ovf <= 1'b0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable_i) begin
                  state      <= ST_COUNT;
                  gate_len_q <= start_len;
                  gate_cnt   <= '0;
                  edge_cnt   <= '0;
                  sticky_ovf <= 1'b0;
               end
            end
            ST_COUNT: begin
               if (terminal) begin
                  // Edge seen in the terminal cycle belongs to the closing window;
                  // the next window starts immediately with a fresh length.
                  count_q    <= edge_cnt_nxt;
                  ovf_q      <= sticky_nxt;
                  valid_q    <= 1'b1;
                  gate_len_q <= start_len;
                  gate_cnt   <= '0;
                  edge_cnt   <= '0;
                  sticky_ovf <= 1'b0;
                  if (!enable_i) begin
                     state <= ST_IDLE;
                  end
               end else if (!enable_i) begin
                  state      <= ST_IDLE;
                  gate_cnt   <= '0;
                  edge_cnt   <= '0;
                  sticky_ovf <= 1'b0;
               end else begin
                  gate_cnt   <= gate_cnt + GATE_ONE;
                  edge_cnt   <= edge_cnt_nxt;
                  sticky_ovf <= sticky_nxt;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign counter_val_o     = edge_cnt;
   assign count_o           = count_q;
   assign count_valid_o     = valid_q;
   assign trigger_o         = valid_q;
   assign overflow_o        = ovf_q;
   assign counter_cleared_o = (edge_cnt == '0);

endmodule

// File: tb/tb_edge_window_counter.sv
// Directed bench for edge_window_counter: a queue of expected window results
// is filled by the stimulus and drained by a monitor on every strobe.
module tb_edge_window_counter;
   import adpll_pkg::*;

   localparam int W     = 20;
   localparam int GW    = 20;
   localparam int W4    = 4;
   localparam int GAP_W = 16;
   localparam int EXP_W = GAP_W + 1 + W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- DUTs ----------------
   edge_window_counter_if #(.WIDTH(W), .GATE_WIDTH(GW)) ifc ();

   edge_window_counter #(.WIDTH(W), .GATE_WIDTH(GW)) dut (
      .fpga_clk_i        (clk),
      .reset_i           (rst),
      .enable_i          (ifc.enable),
      .gate_len_i        (ifc.gate_len),
      .sig_i             (ifc.sig),
      .counter_val_o     (ifc.counter_val),
      .count_o           (ifc.count),
      .count_valid_o     (ifc.count_valid),
      .trigger_o         (ifc.trigger),
      .overflow_o        (ifc.overflow),
      .counter_cleared_o (ifc.counter_cleared)
   );

   logic          en4;
   logic [W4-1:0] cv4;
   logic [W4-1:0] count4;
   logic          valid4;
   logic          trig4;
   logic          ovf4;
   logic          clr4;

   edge_window_counter #(.WIDTH(W4), .GATE_WIDTH(GW)) dut4 (
      .fpga_clk_i        (clk),
      .reset_i           (rst),
      .enable_i          (en4),
      .gate_len_i        (ifc.gate_len),
      .sig_i             (ifc.sig),
      .counter_val_o     (cv4),
      .count_o           (count4),
      .count_valid_o     (valid4),
      .trigger_o         (trig4),
      .overflow_o        (ovf4),
      .counter_cleared_o (clr4)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   logic [EXP_W-1:0] exp_q[$];
   logic [W4:0]      exp4_q[$];
   int unsigned last_strobe = 0;

   function automatic logic [EXP_W-1:0] mk_exp(input int gap, input int cnt, input bit ovf);
      return {GAP_W'(gap), ovf, W'(cnt)};
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- drivers ----------------
   int   sig_half = 0;
   logic sig_man  = 1'b0;

   // Owns sig: toggles every sig_half cycles, or follows sig_man when sig_half is 0.
   initial begin
      int ph;
      ph = 0;
      ifc.sig = 1'b0;
      forever begin
         @(posedge clk);
         #3;
         if (sig_half == 0) begin
            ph = 0;
            ifc.sig = sig_man;
         end else begin
            ph++;
            if (ph >= sig_half) begin
               ph = 0;
               ifc.sig = ~ifc.sig;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_strobe(input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ifc.count_valid && n < limit);
      if (!ifc.count_valid) check("strobe_timeout", 0, 1);
   endtask

   // ---------------- monitors ----------------
   initial begin
      logic [EXP_W-1:0] e;
      forever begin
         @(negedge clk);
         if (ifc.count_valid || ifc.trigger) check("trigger_align", ifc.trigger, ifc.count_valid);
         if (ifc.count_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", ifc.count, -1);
            end else begin
               e = exp_q.pop_front();
               check("window_count", ifc.count, e[W-1:0]);
               check("window_overflow", ifc.overflow, e[W]);
               if (e[EXP_W-1 -: GAP_W] != '0)
                  check("strobe_gap", cyc - last_strobe, e[EXP_W-1 -: GAP_W]);
            end
            last_strobe = cyc;
         end
      end
   end

   initial begin
      logic [W4:0] e;
      forever begin
         @(negedge clk);
         if (valid4 || trig4) check("sat_trigger_align", trig4, valid4);
         if (valid4) begin
            if (exp4_q.size() == 0) begin
               check("sat_unexpected_strobe", count4, -1);
            end else begin
               e = exp4_q.pop_front();
               check("sat_count", count4, e[W4-1:0]);
               check("sat_overflow", ovf4, e[W4]);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int unsigned r_cyc;

      // Reset held 3 cycles with sig toggling every cycle.
      rst = 1'b1;
      ifc.enable = 1'b0;
      ifc.gate_len = GW'(100);
      en4 = 1'b0;
      sig_half = 1;
      step(3);
      check("rst_counter_val", ifc.counter_val, 0);
      check("rst_count", ifc.count, 0);
      check("rst_count_valid", ifc.count_valid, 0);
      check("rst_trigger", ifc.trigger, 0);
      check("rst_overflow", ifc.overflow, 0);
      check("rst_cleared", ifc.counter_cleared, 1);
      check("rst_state", dut.state, ST_IDLE);
      check("rst_sat_cv", cv4, 0);
      check("rst_sat_cleared", clr4, 1);
      rst = 1'b0;
      sig_half = 0;
      sig_man = 1'b0;
      step(4);
      check("idle_cleared", ifc.counter_cleared, 1);

      // Basic count: period 10, window 100 -> 10 per window.
      exp_q.push_back(mk_exp(0, 10, 0));
      exp_q.push_back(mk_exp(100, 10, 0));
      exp_q.push_back(mk_exp(100, 10, 0));
      sig_half = 5;
      ifc.enable = 1'b1;
      repeat (3) wait_strobe(150);
      step(1);
      ifc.enable = 1'b0;
      step(3);

      // Abort at cycle 50 of 100: no strobe, count_o retained.
      ifc.enable = 1'b1;
      step(50);
      ifc.enable = 1'b0;
      step(2);
      check("abort_counter_val", ifc.counter_val, 0);
      check("abort_state", dut.state, ST_IDLE);
      check("abort_count_held", ifc.count, 10);
      check("abort_cleared", ifc.counter_cleared, 1);
      step(120);
      exp_q.push_back(mk_exp(0, 10, 0));
      ifc.enable = 1'b1;
      r_cyc = cyc;
      wait_strobe(150);
      check("reenable_window_len", cyc - r_cyc, 101);
      step(1);
      ifc.enable = 1'b0;

      // Boundary: edge in terminal cycle counts old window, edge in strobe
      // cycle counts new window.
      sig_half = 0;
      sig_man = 1'b0;
      step(4);
      ifc.gate_len = GW'(20);
      exp_q.push_back(mk_exp(0, 0, 0));
      ifc.enable = 1'b1;
      wait_strobe(40);
      step(17);
      sig_man = 1'b1;
      exp_q.push_back(mk_exp(20, 1, 0));
      step(6);
      sig_man = 1'b0;
      exp_q.push_back(mk_exp(20, 0, 0));
      step(15);
      sig_man = 1'b1;
      exp_q.push_back(mk_exp(20, 1, 0));
      wait_strobe(10);
      check("strobe_cycle_cv", ifc.counter_val, 0);
      @(negedge clk);
      check("new_window_cv", ifc.counter_val, 1);
      check("new_window_cleared", ifc.counter_cleared, 0);
      step(2);
      sig_man = 1'b0;
      wait_strobe(30);
      step(1);
      ifc.enable = 1'b0;
      step(3);

      // Saturation on the 4-bit instance: period 4, window 100 -> 15 + overflow,
      // then a 20-cycle window (5 edges) clears the sticky bit.
      ifc.gate_len = GW'(100);
      exp4_q.push_back({1'b1, W4'(15)});
      exp4_q.push_back({1'b1, W4'(15)});
      sig_half = 2;
      en4 = 1'b1;
      step(150);
      ifc.gate_len = GW'(20);
      exp4_q.push_back({1'b0, W4'(5)});
      step(75);
      en4 = 1'b0;
      check("sat_queue_drained", exp4_q.size(), 0);

      // Gate length 0 -> strobe every cycle; mid-window changes apply next window;
      // enable falling on the terminal cycle still publishes.
      sig_half = 0;
      sig_man = 1'b0;
      step(4);
      exp_q.push_back(mk_exp(0, 0, 0));
      repeat (4) exp_q.push_back(mk_exp(1, 0, 0));
      exp_q.push_back(mk_exp(100, 0, 0));
      exp_q.push_back(mk_exp(20, 0, 0));
      exp_q.push_back(mk_exp(20, 0, 0));
      ifc.gate_len = GW'(0);
      ifc.enable = 1'b1;
      step(5);
      ifc.gate_len = GW'(100);
      step(45);
      ifc.gate_len = GW'(20);
      step(95);
      ifc.enable = 1'b0;
      step(5);
      check("terminal_drop_state", dut.state, ST_IDLE);
      check("terminal_drop_queue", exp_q.size(), 0);

      // Reset mid-window discards it and clears count_o.
      sig_half = 5;
      exp_q.push_back(mk_exp(0, 2, 0));
      ifc.enable = 1'b1;
      wait_strobe(40);
      step(10);
      rst = 1'b1;
      ifc.enable = 1'b0;
      step(2);
      check("midrst_count", ifc.count, 0);
      check("midrst_counter_val", ifc.counter_val, 0);
      check("midrst_valid", ifc.count_valid, 0);
      check("midrst_state", dut.state, ST_IDLE);
      rst = 1'b0;
      sig_half = 0;
      step(40);

      check("main_queue_drained", exp_q.size(), 0);
      check("sat_queue_final", exp4_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
